// File: rtl/fpu_issue_sched_pkg.sv
// Shared types and constants for the FPU issue-slot scheduler.
package fpu_issue_sched_pkg;

    localparam int unsigned FPU_PORTS      = 6;
    localparam int unsigned FPU_CLUSTERS   = 3;
    localparam int unsigned FPU_PORT_IDX_W = 3;
    localparam int unsigned FPU_CNT_W      = 5;

    typedef logic [FPU_PORT_IDX_W-1:0] fpu_port_idx_t;
    typedef logic [FPU_CNT_W-1:0]      fpu_div_cnt_t;

    // Pipelined ops try odd ports first so even ports stay open for iterative ops
    localparam fpu_port_idx_t FPU_PORT_ORDER [FPU_PORTS] =
        '{3'd1, 3'd3, 3'd5, 3'd0, 3'd2, 3'd4};

endpackage

// File: rtl/fpu_issue_sched_div_occ.sv
// Per-cluster iterative-unit occupancy counter: load on issue, count down,
// pulse done one cycle after the count reaches zero; flush cancels silently.
module fpu_div_occ
    import fpu_issue_sched_pkg::*;
#(
    parameter int unsigned DIV_LAT = 20,
    parameter int unsigned CNT_W   = FPU_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic flush,
    output logic busy,
    output logic done,
    output logic wb_due_c
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Next count: flush wins, then a fresh issue, then count down
    always_comb begin
        cnt_nxt = cnt;
        if (flush) begin
            cnt_nxt = '0;
        end else if (load) begin
            cnt_nxt = CNT_W'(DIV_LAT);
        end else if (cnt != '0) begin
            cnt_nxt = cnt - CNT_W'(1);
        end
    end

    // Counter and registered status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            busy <= (cnt_nxt != '0);
            done <= (cnt == CNT_W'(1)) && !flush;
        end
    end

    // Writeback slot is claimed during the last busy cycle
    assign wb_due_c = (cnt == CNT_W'(1));

endmodule

// File: rtl/fpu_issue_sched.sv
// Round-robin issue scheduler for the six FPU ports (three clusters of two).
// Optional perf counters are built when FPU_SCHED_PERF_EN is defined.
module fpu_issue_sched
    import fpu_issue_sched_pkg::*;
#(
    parameter int unsigned NREQ    = 8,
    parameter int unsigned DIV_LAT = 20,
    parameter int unsigned CNT_W   = FPU_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_vld,
    input  logic [NREQ-1:0]     req_div,
    input  logic                stall,
    input  logic                flush,
    output logic [NREQ-1:0]     gnt,
    output logic [3*NREQ-1:0]   gnt_port,
    output logic [5:0]          port_en,
    output logic [17:0]         port_src,
    output logic [2:0]          div_busy,
    output logic [2:0]          div_done,
    output logic [31:0]         perf_gnt,
    output logic [31:0]         perf_miss
);

    localparam int unsigned IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned PIDX_W = $clog2(FPU_PORTS);
    localparam int unsigned CIDX_W = $clog2(FPU_CLUSTERS);
    localparam int unsigned GP_W   = $clog2(3 * NREQ);
    localparam int unsigned SP_W   = $clog2(3 * FPU_PORTS);

    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        last_c;
    logic                    any_c;
    logic [NREQ-1:0]         gnt_c;
    logic [3*NREQ-1:0]       gnt_port_c;
    logic [FPU_PORTS-1:0]    used_c;
    logic [3*FPU_PORTS-1:0]  src_c;
    logic [FPU_CLUSTERS-1:0] div_load_c;
    logic [FPU_CLUSTERS-1:0] wb_due_c;

    // Single-pass allocation in round-robin order starting at rr_ptr
    always_comb begin
        int   r;
        int   p;
        int   q;
        logic found;
        gnt_c      = '0;
        gnt_port_c = '0;
        used_c     = '0;
        src_c      = '0;
        div_load_c = '0;
        any_c      = 1'b0;
        last_c     = '0;
        r          = 0;
        p          = 0;
        q          = 0;
        found      = 1'b0;
        if (!(stall || flush)) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                r     = (int'(rr_ptr) + i) % int'(NREQ);
                found = 1'b0;
                p     = 0;
                if (req_vld[IDX_W'(r)]) begin
                    if (req_div[IDX_W'(r)]) begin
                        for (int c = 0; c < int'(FPU_CLUSTERS); c++) begin
                            if (!found && !div_busy[CIDX_W'(c)] &&
                                !used_c[PIDX_W'(2*c)] && !wb_due_c[CIDX_W'(c)]) begin
                                found                     = 1'b1;
                                p                         = 2 * c;
                                div_load_c[CIDX_W'(c)]    = 1'b1;
                            end
                        end
                    end else begin
                        for (int k = 0; k < int'(FPU_PORTS); k++) begin
                            q = int'(FPU_PORT_ORDER[PIDX_W'(k)]);
                            if (!found && !used_c[PIDX_W'(q)] &&
                                !((q % 2 == 0) && wb_due_c[CIDX_W'(q / 2)])) begin
                                found = 1'b1;
                                p     = q;
                            end
                        end
                    end
                    if (found) begin
                        gnt_c[IDX_W'(r)]               = 1'b1;
                        gnt_port_c[GP_W'(3*r) +: 3]    = 3'(p);
                        used_c[PIDX_W'(p)]             = 1'b1;
                        src_c[SP_W'(3*p) +: 3]         = 3'(r);
                        any_c                          = 1'b1;
                        last_c                         = IDX_W'(r);
                    end
                end
            end
        end
    end

    assign gnt      = gnt_c;
    assign gnt_port = gnt_port_c;

    // Registered port valids/sources and round-robin pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            port_en  <= '0;
            port_src <= '0;
            rr_ptr   <= '0;
        end else begin
            port_en  <= used_c;
            port_src <= src_c;
            if (any_c) begin
                rr_ptr <= IDX_W'((int'(last_c) + 1) % int'(NREQ));
            end
        end
    end

    // One iterative unit per cluster
    for (genvar c = 0; c < FPU_CLUSTERS; c++) begin : g_occ
        fpu_div_occ #(
            .DIV_LAT (DIV_LAT),
            .CNT_W   (CNT_W)
        ) u_occ (
            .clk      (clk),
            .rst      (rst),
            .load     (div_load_c[c]),
            .flush    (flush),
            .busy     (div_busy[c]),
            .done     (div_done[c]),
            .wb_due_c (wb_due_c[c])
        );
    end

`ifdef FPU_SCHED_PERF_EN
    // Grant and missed-request counters, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_gnt  <= '0;
            perf_miss <= '0;
        end else begin
            perf_gnt <= perf_gnt + 32'($countones(gnt_c));
            if (((req_vld & ~gnt_c) != '0) && !stall) begin
                perf_miss <= perf_miss + 32'd1;
            end
        end
    end
`else
    assign perf_gnt  = '0;
    assign perf_miss = '0;
`endif

endmodule

// File: doc/fpu_issue_sched.md
Name: fpu_issue_sched

Overview:
- Issue-slot scheduler for the six FPU input ports (u1..u6) of the three-cluster half-width FPU (clusters 0/1/2 = port pairs 0-1, 2-3, 4-5).
- Each cycle it grants up to six of NREQ requesters to ports by round-robin.
- Gives iterative ops (fdiv/fsqrt) one per-cluster iterative unit, issued only via the cluster's even port.
- Tracks iterative-unit occupancy and reserves the writeback slot.

Parameters:
- NREQ, 8, number of requesters.
- DIV_LAT, 20, iterative-op latency in cycles, grant to result; legal range 2..31.
- CNT_W, 5, occupancy counter width; must hold DIV_LAT.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- req_vld  input  NREQ  request valid per requester.
- req_div  input  NREQ  request is an iterative op; ignored when req_vld=0.
- stall  input  1  backend stall; suppresses all grants.
- flush  input  1  pipeline flush; cancels in-flight iterative ops.
- gnt  output  NREQ  combinational grant, same cycle as request.
- gnt_port  output  3*NREQ  port index 0..5 per granted requester; 0 when not granted.
- port_en  output  6  registered port-valid, drives the valid bit of u*_en.
- port_src  output  18  registered requester index per port, 3 bits each.
- div_busy  output  3  iterative unit occupied, per cluster.
- div_done  output  3  one-cycle pulse on iterative result return, per cluster.
- perf_gnt  output  32  total grants (optional feature).
- perf_miss  output  32  cycles with a valid request left ungranted (optional feature).

Behaviour:
- Reset: all outputs 0, rr_ptr=0, all counters 0.
- Allocation is a combinational single pass. Requesters are visited in order rr_ptr, rr_ptr+1, ... mod NREQ.
- Pipelined request: takes the first free port in order 1,3,5,0,2,4. Odd ports are preferred so even ports stay free for iterative ops.
- Iterative request: takes the lowest cluster c where cnt[c]==0, port 2c is free, and port 2c is not reserved. At most one iterative grant per cluster per cycle.
- Reservation: when cnt[c]==1, port 2c is reserved for writeback that cycle and granted to nobody.
- No eligible port: the requester is not granted, and later requesters are still evaluated.
- stall=1 or flush=1: gnt=0. Registered port_en next cycle is 0. rr_ptr holds.
- Registered outputs: port_en/port_src at T+1 reflect grants at T. Latency from request to port_en is 1.
- rr_ptr update: on any grant, becomes (last granted requester index + 1) mod NREQ. Unchanged if no grant.
- Occupancy counter cnt[c]:
  - iterative grant at T loads DIV_LAT at T+1;
  - otherwise decrements when nonzero;
  - div_busy[c] = (cnt[c]!=0);
  - div_done[c] is registered and asserted in the cycle after cnt[c] goes 1 to 0.
- stall does not freeze the counters.
- flush: all cnt cleared next cycle. No div_done for cancelled ops. A done already due in the flush cycle is also suppressed.
- rst asserted mid-operation clears everything asynchronously. No done is produced.
- Widths: gnt_port and port_src are 3-bit fields, LSB field = index 0.

Optional Feature:
- Macro: FPU_SCHED_PERF_EN.
- Defined:
  - perf_gnt adds popcount(gnt) each cycle;
  - perf_miss increments when (req_vld & ~gnt)!=0 and stall=0;
  - both wrap at 2^32;
  - both are cleared by reset only.
- Undefined: counters are not built, and both ports are tied to 0.

Decomposition:
- Shared package holds:
  - FPU_PORTS=6, FPU_CLUSTERS=3;
  - the port-preference order constant {1,3,5,0,2,4};
  - typedef fpu_port_idx_t (3 bits);
  - typedef fpu_div_cnt_t (CNT_W bits).
- One sub-module: fpu_div_occ, a per-cluster occupancy counter with load, flush, busy and done. It is instantiated three times.
- The allocator stays inline.

Test Plan:
- Single pipelined request (req_vld=0x01, req_div=0) -> gnt=0x01, gnt_port[2:0]=1; next cycle port_en=0x02, port_src[5:3]=0, rr_ptr=1.
- All eight pipelined (req_vld=0xFF, rr_ptr=0) -> gnt=0x3F, ports 1,3,5,0,2,4 to requesters 0..5; rr_ptr=6; next cycle rr order gives requesters 6,7 ports 1,3.
- Iterative issue and completion:
  - req_vld=0x01, req_div=0x01 with DIV_LAT=20 -> port 0; div_busy=001 for 20 cycles;
  - the cycle cnt[0]==1, a pipelined request cannot get port 0;
  - div_done[0] pulses one cycle.
- Four iterative requests, all clusters idle -> three grants (ports 0,2,4); the fourth is ungranted; div_busy=111.
- Flush at cycle 10 of an iterative op -> div_busy=000 next cycle, no div_done; same-cycle request gets gnt=0.
- stall=1 with req_vld=0xFF -> gnt=0, port_en=0 next cycle, rr_ptr unchanged, busy counters still decrement.
- With FPU_SCHED_PERF_EN, 8 requests for 1 cycle -> perf_gnt=6, perf_miss=1.
